// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode/funct constants and instruction decode for the
//                ALU operand-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef struct packed {
        logic              legal;
        logic              is_r;
        logic              sext;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [REG_AW-1:0] dest;
        logic [4:0]        shamt;
        logic [5:0]        funct;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        d.legal = 1'b1;
        d.is_r  = 1'b0;
        d.sext  = 1'b0;
        d.src1  = instr[25:21];
        d.src2  = instr[20:16];
        d.dest  = instr[20:16];
        d.shamt = 5'd0;
        d.funct = F_ADD;
        case (instr[31:26])
            OP_RTYPE: begin
                d.is_r  = 1'b1;
                d.dest  = instr[15:11];
                d.shamt = instr[10:6];
                d.funct = instr[5:0];
            end
            OP_ADDI: begin d.funct = F_ADD; d.sext = 1'b1; end
            OP_SLTI: begin d.funct = F_SLT; d.sext = 1'b1; end
            OP_ANDI: d.funct = F_AND;
            OP_ORI:  d.funct = F_OR;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_regfile
//  Description : 2R/1W register file, R0 hardwired to zero, write-through
//                forwarding on both read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [REG_AW-1:0] i_raddr0,
    input  logic [REG_AW-1:0] i_raddr1,
    output logic [31:0]       o_rdata0,
    output logic [31:0]       o_rdata1
);

    logic [31:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A same-cycle write must be seen by the instruction being accepted now.
    always_comb begin
        o_rdata0 = r_mem[i_raddr0];
        if (i_raddr0 == '0)
            o_rdata0 = 32'd0;
        else if (i_we && (i_waddr == i_raddr0))
            o_rdata0 = i_wdata;
    end

    always_comb begin
        o_rdata1 = r_mem[i_raddr1];
        if (i_raddr1 == '0)
            o_rdata1 = 32'd0;
        else if (i_we && (i_waddr == i_raddr1))
            o_rdata1 = i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/alu_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_fetch
//  Description : Decodes R-type and ADDI/SLTI/ANDI/ORI, reads operands,
//                tracks pending writebacks and registers operands for the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_fetch
    import alu_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [31:0]       wb_data,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [31:0]       a,
    output logic [31:0]       b,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [REG_AW-1:0] dest,
    output logic              err
);

    dec_t              w_dec;
    logic [31:0]       w_rs_data;
    logic [31:0]       w_rt_data;
    logic [31:0]       w_b;
    logic [NREGS-1:0]  w_clr_mask;
    logic [NREGS-1:0]  w_set_mask;
    logic [NREGS-1:0]  w_busy_eff;
    logic              w_hazard;
    logic              w_slot_free;
    logic              w_accept;
    logic              w_issue;

    logic [NREGS-1:0]  r_busy;
    logic              r_alu_valid;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [4:0]        r_shamt;
    logic [5:0]        r_funct;
    logic [REG_AW-1:0] r_dest;
    logic              r_err;

    alu_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (wb_en),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data),
        .i_raddr0 (w_dec.src1),
        .i_raddr1 (w_dec.src2),
        .o_rdata0 (w_rs_data),
        .o_rdata1 (w_rt_data)
    );

    assign w_dec = decode(instr);

    // A register whose writeback lands this cycle no longer blocks issue.
    assign w_clr_mask  = wb_en ? (NREGS'(1) << wb_addr) : '0;
    assign w_busy_eff  = r_busy & ~w_clr_mask;
    assign w_hazard    = w_busy_eff[w_dec.src1]
                       | (w_dec.is_r & w_busy_eff[w_dec.src2])
                       | w_busy_eff[w_dec.dest];
    assign w_slot_free = !r_alu_valid || alu_ready;
    assign instr_ready = w_slot_free && (!w_dec.legal || !w_hazard);
    assign w_accept    = instr_valid && instr_ready;
    assign w_issue     = w_accept && w_dec.legal;
    assign w_set_mask  = (w_issue && (w_dec.dest != '0)) ? (NREGS'(1) << w_dec.dest) : '0;

    always_comb begin
        w_b = w_rt_data;
        if (!w_dec.is_r)
            w_b = w_dec.sext ? {{16{instr[15]}}, instr[15:0]} : {16'd0, instr[15:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= '0;
            r_alu_valid <= 1'b0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_shamt     <= 5'd0;
            r_funct     <= 6'd0;
            r_dest      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_busy <= w_busy_eff | w_set_mask;
            r_err  <= w_accept && !w_dec.legal;
            if (w_issue) begin
                r_alu_valid <= 1'b1;
                r_a         <= w_rs_data;
                r_b         <= w_b;
                r_shamt     <= w_dec.shamt;
                r_funct     <= w_dec.funct;
                r_dest      <= w_dec.dest;
            end else if (alu_ready) begin
                r_alu_valid <= 1'b0;
            end
        end
    end

    assign alu_valid = r_alu_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign shamt     = r_shamt;
    assign funct     = r_funct;
    assign dest      = r_dest;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_fetch
//  Description : Directed and randomized checking of alu_operand_fetch
//                against a behavioural model of the stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [4:0]  dest;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_shamt, m_dest;
    logic [5:0]  m_funct;
    logic        m_err;

    always #5 clk = ~clk;

    alu_operand_fetch #(.NREGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .a           (a),
        .b           (b),
        .shamt       (shamt),
        .funct       (funct),
        .dest        (dest),
        .err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_valid = 0; m_a = 0; m_b = 0; m_shamt = 0; m_funct = 0; m_dest = 0; m_err = 0;
    endtask

    function automatic logic m_legal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h08) || (op == 6'h0A) || (op == 6'h0C) || (op == 6'h0D);
    endfunction

    function automatic logic m_blocked(input logic [4:0] r);
        return m_busy[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic m_ready();
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic       haz;
        op  = instr[31:26];
        rs  = instr[25:21];
        rt  = instr[20:16];
        rd  = (op == 6'h00) ? instr[15:11] : rt;
        haz = m_blocked(rs) || (op == 6'h00 && m_blocked(rt)) || m_blocked(rd);
        return (!m_valid || alu_ready) && (!m_legal(op) || !haz);
    endfunction

    task automatic m_edge(input logic acc);
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        op = instr[31:26];
        rs = instr[25:21];
        rt = instr[20:16];
        rd = (op == 6'h00) ? instr[15:11] : rt;
        if (acc && m_legal(op)) begin
            m_valid = 1;
            m_a     = m_read(rs);
            m_dest  = rd;
            if (op == 6'h00) begin
                m_b = m_read(rt); m_shamt = instr[10:6]; m_funct = instr[5:0];
            end else begin
                m_shamt = 0;
                m_b = (op == 6'h08 || op == 6'h0A) ? {{16{instr[15]}}, instr[15:0]} : {16'd0, instr[15:0]};
                case (op)
                    6'h08:   m_funct = 6'h20;
                    6'h0A:   m_funct = 6'h2A;
                    6'h0C:   m_funct = 6'h24;
                    default: m_funct = 6'h25;
                endcase
            end
        end else if (alu_ready) begin
            m_valid = 0;
        end
        m_err = acc && !m_legal(op);
        if (wb_en) begin
            m_busy[wb_addr] = 0;
            if (wb_addr != 0) m_regs[wb_addr] = wb_data;
        end
        if (acc && m_legal(op) && rd != 0) m_busy[rd] = 1;
    endtask

    // One clock: called just after a falling edge with inputs already driven.
    task automatic cycle();
        logic exp_rdy;
        #1;
        exp_rdy = m_ready();
        chk("instr_ready", {31'd0, instr_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        m_edge(instr_valid && exp_rdy);
        #1;
        chk("alu_valid", {31'd0, alu_valid}, {31'd0, m_valid});
        chk("a", a, m_a);
        chk("b", b, m_b);
        chk("shamt", {27'd0, shamt}, {27'd0, m_shamt});
        chk("funct", {26'd0, funct}, {26'd0, m_funct});
        chk("dest", {27'd0, dest}, {27'd0, m_dest});
        chk("err", {31'd0, err}, {31'd0, m_err});
        @(negedge clk);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic rand_inputs();
        int k, start;
        logic found;
        logic [5:0] fn_tab [6];
        fn_tab[0] = 6'h00; fn_tab[1] = 6'h02; fn_tab[2] = 6'h20;
        fn_tab[3] = 6'h24; fn_tab[4] = 6'h25; fn_tab[5] = 6'h2A;
        instr_valid = ($urandom_range(0, 3) != 0);
        alu_ready   = ($urandom_range(0, 3) != 0);
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3: instr = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                 5'($urandom_range(0, 7)), 5'($urandom), fn_tab[$urandom_range(0, 5)]};
            4: instr = itype(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            5: instr = itype(6'h0A, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            6: instr = itype(6'h0C, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            7: instr = itype(6'h0D, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            8: instr = {6'h3F, 26'($urandom)};
            default: instr = $urandom;
        endcase
        found = 0;
        start = $urandom_range(0, 31);
        wb_addr = 0;
        for (int i = 0; i < 32; i++) begin
            if (!found && m_busy[(start + i) % 32]) begin
                found = 1;
                wb_addr = 5'((start + i) % 32);
            end
        end
        k = $urandom_range(0, 9);
        wb_data = $urandom;
        if (k < 5 && found) begin
            wb_en = 1;
        end else if (k < 7) begin
            wb_en = 1;
            wb_addr = 5'($urandom_range(0, 7));
        end else begin
            wb_en = 0;
        end
    endtask

    task automatic idle();
        instr_valid = 0; instr = 0; wb_en = 0; wb_addr = 0; wb_data = 0; alu_ready = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        m_reset();
        #1;
        chk("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // R1 = 0x1000, R2 = 4, then add r3 = r1 + r2
        wb_en = 1; wb_addr = 1; wb_data = 32'h1000; cycle();
        wb_addr = 2; wb_data = 32'h4; cycle();
        wb_en = 0;
        instr_valid = 1; instr = rtype(5'd3, 5'd1, 5'd2, 6'h20); cycle();
        chk("add_valid", {31'd0, alu_valid}, 32'd1);
        chk("add_a", a, 32'h1000);
        chk("add_b", b, 32'h4);
        chk("add_funct", {26'd0, funct}, 32'h20);
        chk("add_dest", {27'd0, dest}, 32'd3);

        instr = itype(6'h08, 5'd5, 5'd0, 16'hFFFF); cycle();
        chk("addi_b", b, 32'hFFFFFFFF);
        chk("addi_funct", {26'd0, funct}, 32'h20);
        instr = itype(6'h0D, 5'd6, 5'd0, 16'hFFFF); cycle();
        chk("ori_b", b, 32'h0000FFFF);
        chk("ori_funct", {26'd0, funct}, 32'h25);

        // reader of busy R3 waits until its writeback lands
        instr = rtype(5'd4, 5'd3, 5'd0, 6'h20);
        #1;
        chk("hazard_ready", {31'd0, instr_ready}, 32'd0);
        cycle();
        wb_en = 1; wb_addr = 3; wb_data = 32'd7;
        #1;
        chk("fwd_ready", {31'd0, instr_ready}, 32'd1);
        cycle();
        chk("fwd_a", a, 32'd7);

        // stall three cycles; a source write during stall must not disturb held outputs
        wb_en = 0; alu_ready = 0; instr = rtype(5'd7, 5'd1, 5'd2, 6'h25);
        cycle(); chk("stall_a0", a, 32'd7);
        cycle(); chk("stall_a1", a, 32'd7);
        wb_en = 1; wb_addr = 1; wb_data = 32'd9;
        cycle(); chk("stall_a2", a, 32'd7);
        wb_en = 0; alu_ready = 1;
        cycle();
        chk("post_stall_a", a, 32'd9);
        chk("post_stall_b", b, 32'd4);

        // illegal opcode
        instr = {6'h3F, 26'd0}; cycle();
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_no_valid", {31'd0, alu_valid}, 32'd0);
        instr_valid = 0; cycle();
        chk("err_clear", {31'd0, err}, 32'd0);

        // R0 write ignored
        wb_en = 1; wb_addr = 0; wb_data = 32'd55; cycle();
        wb_en = 0; instr_valid = 1; instr = rtype(5'd8, 5'd0, 5'd0, 6'h20); cycle();
        chk("r0_a", a, 32'd0);

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            cycle();
        end

        // asynchronous reset with an operand held and a register busy
        idle();
        instr_valid = 1; instr = rtype(5'd9, 5'd0, 5'd0, 6'h20); cycle();
        chk("pre_rst_valid", {31'd0, alu_valid}, 32'd1);
        idle();
        rst_n = 0;
        #1;
        m_reset();
        chk("async_rst_valid", {31'd0, alu_valid}, 32'd0);
        chk("async_rst_dest", {27'd0, dest}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        instr_valid = 1; instr = rtype(5'd9, 5'd1, 5'd2, 6'h20);
        #1;
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        cycle();
        chk("post_rst_valid", {31'd0, alu_valid}, 32'd1);
        chk("post_rst_a", a, 32'd0);
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
